// File: rtl/raster_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : raster_scan_gen
// Purpose  : Strided 2-D raster (row, col) generator on a valid/ready stream,
//            with optional incremental linear address (RASTER_SCAN_GEN_LINEAR_EN).
// Revision : 1.0
// ============================================================================
module raster_scan_gen #(
   parameter int W  = 5,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  cfg_last_col,
   input  logic [W-1:0]  cfg_last_row,
   input  logic [W-1:0]  cfg_step,
   input  logic [AW-1:0] cfg_pitch,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_row,
   output logic [W-1:0]  out_col,
   output logic [AW-1:0] out_addr,
   output logic          out_first,
   output logic          out_eol,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [W-1:0]  last_col_q, last_col_d;
   logic [W-1:0]  last_row_q, last_row_d;
   logic [W-1:0]  step_q, step_d;
   logic [W-1:0]  row_q, row_d;
   logic [W-1:0]  col_q, col_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;

   logic [W-1:0]  step_eff;
   logic [W:0]    col_sum;
   logic [W:0]    row_sum;
   logic          eol_w;
   logic          last_w;
   logic          accept_w;

   // Zero stride is promoted to one once, at latch time, so the datapath never sees it.
   assign step_eff = (cfg_step == '0) ? C_ONE : cfg_step;

   assign col_sum  = {1'b0, col_q} + {1'b0, step_q};
   assign row_sum  = {1'b0, row_q} + {1'b0, step_q};
   assign eol_w    = (col_sum > {1'b0, last_col_q});
   assign last_w   = eol_w && (row_sum > {1'b0, last_row_q});
   assign accept_w = valid_q && out_ready;

`ifdef RASTER_SCAN_GEN_LINEAR_EN
   logic [AW-1:0] pitch_q, pitch_d;
   logic [AW-1:0] base_q, base_d;
`else
   logic unused_pitch;
   assign unused_pitch = ^cfg_pitch;
`endif

   always_comb begin
      state_d    = state_q;
      last_col_d = last_col_q;
      last_row_d = last_row_q;
      step_d     = step_q;
      row_d      = row_q;
      col_d      = col_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
`ifdef RASTER_SCAN_GEN_LINEAR_EN
      pitch_d    = pitch_q;
      base_d     = base_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d    = S_RUN;
               last_col_d = cfg_last_col;
               last_row_d = cfg_last_row;
               step_d     = step_eff;
               row_d      = '0;
               col_d      = '0;
               valid_d    = 1'b1;
`ifdef RASTER_SCAN_GEN_LINEAR_EN
               pitch_d    = cfg_pitch;
               base_d     = '0;
`endif
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               row_d   = '0;
               col_d   = '0;
`ifdef RASTER_SCAN_GEN_LINEAR_EN
               base_d  = '0;
`endif
            end else if (accept_w) begin
               if (last_w) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  row_d   = '0;
                  col_d   = '0;
`ifdef RASTER_SCAN_GEN_LINEAR_EN
                  base_d  = '0;
`endif
               end else if (eol_w) begin
                  col_d  = '0;
                  row_d  = row_sum[W-1:0];
`ifdef RASTER_SCAN_GEN_LINEAR_EN
                  base_d = base_q + pitch_q;
`endif
               end else begin
                  col_d = col_sum[W-1:0];
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_col_q <= '0;
         last_row_q <= '0;
         step_q     <= C_ONE;
         row_q      <= '0;
         col_q      <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
`ifdef RASTER_SCAN_GEN_LINEAR_EN
         pitch_q    <= '0;
         base_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         last_col_q <= last_col_d;
         last_row_q <= last_row_d;
         step_q     <= step_d;
         row_q      <= row_d;
         col_q      <= col_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
`ifdef RASTER_SCAN_GEN_LINEAR_EN
         pitch_q    <= pitch_d;
         base_q     <= base_d;
`endif
      end
   end

   assign out_valid = valid_q;
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   // Flags are derived from stale config when idle, so qualify them with valid.
   assign out_first = valid_q && (row_q == '0) && (col_q == '0);
   assign out_eol   = valid_q && eol_w;
   assign out_last  = valid_q && last_w;

`ifdef RASTER_SCAN_GEN_LINEAR_EN
   assign out_addr = base_q + AW'(col_q);
`else
   assign out_addr = '0;
`endif

endmodule
`default_nettype wire
